// File: rtl/counter_sequencer.sv
// Sequencer that owns the up-counter register: programmable limit, prescaler and
// reload mode, with start/pause/stop control, a terminal-count pulse and a done flag.
module counter_sequencer #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_limit,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               cfg_reload,
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic               tc_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   limit;
    logic [PRESC_W-1:0] presc;
    logic               reload;
    logic [PRESC_W-1:0] presc_cnt;

    assign busy      = (state == S_RUN) || (state == S_HOLD);
    assign done      = (state == S_DONE);
    assign cfg_ready = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_IDLE;
            count     <= '0;
            presc_cnt <= '0;
            tc_pulse  <= 1'b0;
            limit     <= '1;
            presc     <= '0;
            reload    <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // Config captured here is what the run started this same edge uses.
                    if (cfg_valid) begin
                        limit  <= cfg_limit;
                        presc  <= cfg_presc;
                        reload <= cfg_reload;
                    end
                    if (start) begin
                        state     <= S_RUN;
                        count     <= '0;
                        presc_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state     <= S_IDLE;
                        count     <= '0;
                        presc_cnt <= '0;
                    end else if (pause) begin
                        state <= S_HOLD;
                    end else if (presc_cnt == presc) begin
                        presc_cnt <= '0;
                        if (count == limit) begin
                            tc_pulse <= 1'b1;
                            if (reload) begin
                                count <= '0;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        presc_cnt <= presc_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    // Resuming only returns to RUN; counting restarts from the frozen values.
                    if (stop) begin
                        state     <= S_IDLE;
                        count     <= '0;
                        presc_cnt <= '0;
                    end else if (!pause) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: per-cycle vector table plus hand-written
// sequences for reset, pause/stop, limit=0 and full-range wrap.
module tb_counter_sequencer;

    logic       clk;
    logic       clr;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_limit;
    logic [3:0] cfg_presc;
    logic       cfg_reload;
    logic       start;
    logic       pause;
    logic       stop;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       tc_pulse;

    int pass_cnt = 0;
    int total    = 0;

    counter_sequencer #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_limit (cfg_limit),
        .cfg_presc (cfg_presc),
        .cfg_reload(cfg_reload),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .tc_pulse  (tc_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       cv;
        logic [7:0] lim;
        logic [3:0] pre;
        logic       rel;
        logic       st;
        logic       pa;
        logic       sp;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_done;
        logic       e_tc;
        logic       e_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic cv, logic [7:0] lim, logic [3:0] pre, logic rel,
                                logic st, logic pa, logic sp, logic [7:0] ec, logic eb,
                                logic ed, logic et, logic er);
        vec_t v;
        v.clr = c; v.cv = cv; v.lim = lim; v.pre = pre; v.rel = rel;
        v.st = st; v.pa = pa; v.sp = sp;
        v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_tc = et; v.e_ready = er;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; start = 0; pause = 0; stop = 0;
    endtask

    task automatic cfg_start(input logic [7:0] lim, input logic [3:0] pre, input logic rel);
        cfg_valid = 1; cfg_limit = lim; cfg_presc = pre; cfg_reload = rel; start = 1;
        step();
        idle_inputs();
    endtask

    initial begin
        clk = 0; clr = 0; cfg_limit = 0; cfg_presc = 0; cfg_reload = 0;
        idle_inputs();

        //             clr cv lim pre rel st pa sp | cnt busy done tc rdy
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1)); // reset
        tbl.push_back(mk(1, 1, 3, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0)); // one-shot limit 3
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 1, 0, 0,   0, 1, 0, 0, 0)); // periodic limit 2 presc 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0)); // cfg in RUN ignored
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1)); // stop
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0)); // restart, old config kept
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            clr = tbl[i].clr; cfg_valid = tbl[i].cv; cfg_limit = tbl[i].lim;
            cfg_presc = tbl[i].pre; cfg_reload = tbl[i].rel;
            start = tbl[i].st; pause = tbl[i].pa; stop = tbl[i].sp;
            step();
            chk($sformatf("vec%0d", i), {count, busy, done, tc_pulse, cfg_ready},
                {tbl[i].e_count, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_tc, tbl[i].e_ready});
        end
        idle_inputs();

        // Pause at count 5, resume, then stop together with pause.
        cfg_start(8'd10, 4'd0, 1'b0);
        chk("t4_start", count, 0);
        repeat (5) step();
        chk("t4_at5", count, 5);
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t4_hold%0d", i), {count, busy, tc_pulse}, {8'd5, 1'b1, 1'b0});
        end
        pause = 0;
        step();
        chk("t4_resume0", count, 5);
        step();
        chk("t4_resume1", count, 6);
        pause = 1; stop = 1;
        step();
        chk("t4_stop", {count, busy, tc_pulse, cfg_ready}, {8'd0, 1'b0, 1'b0, 1'b1});
        idle_inputs();
        step();
        chk("t4_idle", {count, tc_pulse}, 0);

        // limit=0 periodic: count pinned at 0, tc every presc+1 clocks.
        cfg_start(8'd0, 4'd2, 1'b1);
        chk("t5_start", {count, busy}, {8'd0, 1'b1});
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("t5_k%0d", k), {count, tc_pulse}, {8'd0, (k % 3 == 0)});
        end
        stop = 1; step(); stop = 0;

        // Full-range reload wrap; a start request while busy must change nothing.
        cfg_start(8'd255, 4'd0, 1'b1);
        chk("t6_start", count, 0);
        for (int k = 1; k <= 520; k++) begin
            start = (k == 100);
            step();
            chk($sformatf("t6_k%0d", k), {count, tc_pulse, busy}, {k[7:0], (k % 256 == 0), 1'b1});
        end
        start = 0;
        stop = 1; step(); stop = 0;

        // Reset mid-run, then confirm config registers returned to defaults.
        cfg_start(8'd10, 4'd3, 1'b1);
        repeat (8) step();
        chk("t1_pre", count, 2);
        clr = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("t1_rst%0d", i), {count, busy, done, tc_pulse, cfg_ready},
                {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        clr = 1;
        step();
        chk("t1_after", {count, busy, done, tc_pulse, cfg_ready}, {8'd0, 4'b0001});
        start = 1; step(); start = 0;
        repeat (3) step();
        chk("t1_defaults", {count, busy}, {8'd3, 1'b1});

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
